// File: rtl/uart_mmio_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_mmio_if
//  Description : Core data-bus bundle between the riscv core (master) and the
//                memory-mapped UART responder (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_mmio_if;
   logic [31:0] adr;
   logic [31:0] writedata;
   logic        memwrite;
   logic        memread;
   logic [31:0] readdata;
   logic        hit;

   modport master (
      output adr, writedata, memwrite, memread,
      input  readdata, hit
   );

   modport slave (
      input  adr, writedata, memwrite, memread,
      output readdata, hit
   );
endinterface
`default_nettype wire

// File: rtl/uart_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : uart_mmio
//  Description : Memory-mapped UART on the core data bus. 16-byte window with
//                RXDATA / TXDATA / STATUS registers, RX deserializer feeding an
//                RX FIFO, TX FIFO feeding a serializer, sticky error flags.
//                Read data is registered (one-cycle latency, same as BRAM).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_mmio #(
   parameter int          CLK_PER_BIT = 868,
   parameter int          FIFO_DEPTH  = 16,
   parameter logic [31:0] BASE        = 32'h8000_0000
) (
   input  logic       clk,
   input  logic       rst,
   uart_mmio_if.slave bus,
   output logic       txd,
   input  logic       rxd
);

   localparam int              c_AW        = $clog2(FIFO_DEPTH);
   localparam int              c_CW        = c_AW + 1;
   localparam logic [c_CW-1:0] c_FULL      = c_CW'(FIFO_DEPTH);
   localparam logic [15:0]     c_BIT_LAST  = 16'(CLK_PER_BIT - 1);
   localparam logic [15:0]     c_HALF_LAST = 16'(CLK_PER_BIT / 2 - 1);

   localparam logic [1:0] c_REG_RXDATA = 2'd0;
   localparam logic [1:0] c_REG_TXDATA = 2'd1;
   localparam logic [1:0] c_REG_STATUS = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // Bus decode. A simultaneous write and read executes only the write.
   // ------------------------------------------------------------------------
   logic       w_sel;
   logic       w_wr;
   logic       w_rd;
   logic [1:0] w_reg;
   logic       w_unused;

   assign w_sel    = (bus.adr[31:4] == BASE[31:4]);
   assign w_wr     = w_sel & bus.memwrite;
   assign w_rd     = w_sel & bus.memread & ~bus.memwrite;
   assign w_reg    = bus.adr[3:2];
   assign w_unused = ^{bus.adr[1:0], bus.writedata[31:8]};

   // ------------------------------------------------------------------------
   // FIFO state
   // ------------------------------------------------------------------------
   logic [7:0]      r_rx_mem [FIFO_DEPTH];
   logic [c_AW-1:0] r_rx_wr;
   logic [c_AW-1:0] r_rx_rd;
   logic [c_CW-1:0] r_rx_count;

   logic [7:0]      r_tx_mem [FIFO_DEPTH];
   logic [c_AW-1:0] r_tx_wr;
   logic [c_AW-1:0] r_tx_rd;
   logic [c_CW-1:0] r_tx_count;

   logic w_rx_empty;
   logic w_rx_full;
   logic w_tx_empty;
   logic w_tx_full;

   assign w_rx_empty = (r_rx_count == '0);
   assign w_rx_full  = (r_rx_count == c_FULL);
   assign w_tx_empty = (r_tx_count == '0);
   assign w_tx_full  = (r_tx_count == c_FULL);

   // ------------------------------------------------------------------------
   // Serializer / deserializer state
   // ------------------------------------------------------------------------
   state_t      r_tx_state;
   logic [15:0] r_tx_cnt;
   logic [2:0]  r_tx_bit;
   logic [7:0]  r_tx_shift;
   logic        r_txd;

   state_t      r_rx_state;
   logic [15:0] r_rx_cnt;
   logic [2:0]  r_rx_bit;
   logic [7:0]  r_rx_shift;
   logic        r_rx_s1;
   logic        r_rx_s2;
   logic        r_rx_s3;
   logic        r_rx_push_req;
   logic        r_rx_frm_req;

   logic r_rx_ovr;
   logic r_tx_ovf;
   logic r_frm_err;

   // ------------------------------------------------------------------------
   // Push/pop qualification. A pop in the same cycle frees a slot, so a push
   // into a full FIFO is accepted whenever that FIFO is also being popped.
   // ------------------------------------------------------------------------
   logic       w_rx_pop;
   logic       w_rx_push;
   logic       w_rx_ovr_set;
   logic       w_tx_pop;
   logic       w_tx_push_req;
   logic       w_tx_push;
   logic       w_tx_ovf_set;
   logic [2:0] w_clr;
   logic       w_tx_busy;
   logic [31:0] w_status;
   logic [31:0] w_rdata;

   assign w_rx_pop      = w_rd && (w_reg == c_REG_RXDATA) && !w_rx_empty;
   assign w_rx_push     = r_rx_push_req && (!w_rx_full || w_rx_pop);
   assign w_rx_ovr_set  = r_rx_push_req && w_rx_full && !w_rx_pop;

   assign w_tx_pop      = (r_tx_state == ST_IDLE) && !w_tx_empty;
   assign w_tx_push_req = w_wr && (w_reg == c_REG_TXDATA);
   assign w_tx_push     = w_tx_push_req && (!w_tx_full || w_tx_pop);
   assign w_tx_ovf_set  = w_tx_push_req && w_tx_full && !w_tx_pop;

   assign w_clr     = (w_wr && (w_reg == c_REG_STATUS)) ? bus.writedata[5:3] : 3'b000;
   assign w_tx_busy = !w_tx_empty || (r_tx_state != ST_IDLE);
   assign w_status  = {26'b0, r_frm_err, r_tx_ovf, r_rx_ovr, w_tx_busy, w_tx_full, !w_rx_empty};

   // Read mux; an empty RXDATA read returns zero.
   always_comb begin
      w_rdata = 32'b0;
      case (w_reg)
         c_REG_RXDATA: w_rdata = w_rx_empty ? 32'b0 : {24'b0, r_rx_mem[r_rx_rd]};
         c_REG_STATUS: w_rdata = w_status;
         default:      w_rdata = 32'b0;
      endcase
   end

   // Registered read data and hit marker for the top-level readdata mux.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.readdata <= 32'b0;
         bus.hit      <= 1'b0;
      end else begin
         bus.hit      <= w_rd;
         bus.readdata <= w_rd ? w_rdata : 32'b0;
      end
   end

   // RX FIFO storage (no reset needed: contents are only read when counted).
   always_ff @(posedge clk) begin
      if (w_rx_push) begin
         r_rx_mem[r_rx_wr] <= r_rx_shift;
      end
   end

   // RX FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_wr    <= '0;
         r_rx_rd    <= '0;
         r_rx_count <= '0;
      end else begin
         if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
         if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
         case ({w_rx_push, w_rx_pop})
            2'b10:   r_rx_count <= r_rx_count + 1'b1;
            2'b01:   r_rx_count <= r_rx_count - 1'b1;
            default: r_rx_count <= r_rx_count;
         endcase
      end
   end

   // TX FIFO storage.
   always_ff @(posedge clk) begin
      if (w_tx_push) begin
         r_tx_mem[r_tx_wr] <= bus.writedata[7:0];
      end
   end

   // TX FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_wr    <= '0;
         r_tx_rd    <= '0;
         r_tx_count <= '0;
      end else begin
         if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
         if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
         case ({w_tx_push, w_tx_pop})
            2'b10:   r_tx_count <= r_tx_count + 1'b1;
            2'b01:   r_tx_count <= r_tx_count - 1'b1;
            default: r_tx_count <= r_tx_count;
         endcase
      end
   end

   // Sticky error flags; a set event in the same cycle as its clear wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_ovr  <= 1'b0;
         r_tx_ovf  <= 1'b0;
         r_frm_err <= 1'b0;
      end else begin
         r_rx_ovr  <= w_rx_ovr_set  | (r_rx_ovr  & ~w_clr[0]);
         r_tx_ovf  <= w_tx_ovf_set  | (r_tx_ovf  & ~w_clr[1]);
         r_frm_err <= r_rx_frm_req  | (r_frm_err & ~w_clr[2]);
      end
   end

   // TX serializer: pops in IDLE, then start bit, 8 data bits LSB first, stop.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_state <= ST_IDLE;
         r_tx_cnt   <= 16'd0;
         r_tx_bit   <= 3'd0;
         r_tx_shift <= 8'd0;
         r_txd      <= 1'b1;
      end else begin
         case (r_tx_state)
            ST_IDLE: begin
               r_txd <= 1'b1;
               if (!w_tx_empty) begin
                  r_tx_shift <= r_tx_mem[r_tx_rd];
                  r_tx_cnt   <= 16'd0;
                  r_txd      <= 1'b0;
                  r_tx_state <= ST_START;
               end
            end
            ST_START: begin
               if (r_tx_cnt == c_BIT_LAST) begin
                  r_tx_cnt   <= 16'd0;
                  r_tx_bit   <= 3'd0;
                  r_txd      <= r_tx_shift[0];
                  r_tx_state <= ST_DATA;
               end else begin
                  r_tx_cnt <= r_tx_cnt + 16'd1;
               end
            end
            ST_DATA: begin
               if (r_tx_cnt == c_BIT_LAST) begin
                  r_tx_cnt <= 16'd0;
                  if (r_tx_bit == 3'd7) begin
                     r_txd      <= 1'b1;
                     r_tx_state <= ST_STOP;
                  end else begin
                     r_txd      <= r_tx_shift[1];
                     r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                     r_tx_bit   <= r_tx_bit + 3'd1;
                  end
               end else begin
                  r_tx_cnt <= r_tx_cnt + 16'd1;
               end
            end
            ST_STOP: begin
               r_txd <= 1'b1;
               if (r_tx_cnt == c_BIT_LAST) begin
                  r_tx_cnt   <= 16'd0;
                  r_tx_state <= ST_IDLE;
               end else begin
                  r_tx_cnt <= r_tx_cnt + 16'd1;
               end
            end
            default: r_tx_state <= ST_IDLE;
         endcase
      end
   end

   assign txd = r_txd;

   // Two-flop synchronizer plus one history flop for falling-edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_s1 <= 1'b1;
         r_rx_s2 <= 1'b1;
         r_rx_s3 <= 1'b1;
      end else begin
         r_rx_s1 <= rxd;
         r_rx_s2 <= r_rx_s1;
         r_rx_s3 <= r_rx_s2;
      end
   end

   // RX deserializer: mid-bit sampling; push/framing requests issued one cycle
   // after the stop-bit sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_state    <= ST_IDLE;
         r_rx_cnt      <= 16'd0;
         r_rx_bit      <= 3'd0;
         r_rx_shift    <= 8'd0;
         r_rx_push_req <= 1'b0;
         r_rx_frm_req  <= 1'b0;
      end else begin
         r_rx_push_req <= 1'b0;
         r_rx_frm_req  <= 1'b0;
         case (r_rx_state)
            ST_IDLE: begin
               if (r_rx_s3 && !r_rx_s2) begin
                  r_rx_cnt   <= 16'd0;
                  r_rx_state <= ST_START;
               end
            end
            ST_START: begin
               if (r_rx_cnt == c_HALF_LAST) begin
                  r_rx_cnt <= 16'd0;
                  r_rx_bit <= 3'd0;
                  // A line already back high at mid start bit was a glitch.
                  r_rx_state <= r_rx_s2 ? ST_IDLE : ST_DATA;
               end else begin
                  r_rx_cnt <= r_rx_cnt + 16'd1;
               end
            end
            ST_DATA: begin
               if (r_rx_cnt == c_BIT_LAST) begin
                  r_rx_cnt   <= 16'd0;
                  r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                  if (r_rx_bit == 3'd7) begin
                     r_rx_state <= ST_STOP;
                  end else begin
                     r_rx_bit <= r_rx_bit + 3'd1;
                  end
               end else begin
                  r_rx_cnt <= r_rx_cnt + 16'd1;
               end
            end
            ST_STOP: begin
               if (r_rx_cnt == c_BIT_LAST) begin
                  r_rx_cnt      <= 16'd0;
                  r_rx_state    <= ST_IDLE;
                  r_rx_push_req <= r_rx_s2;
                  r_rx_frm_req  <= !r_rx_s2;
               end else begin
                  r_rx_cnt <= r_rx_cnt + 16'd1;
               end
            end
            default: r_rx_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_mmio
//  Description : Directed self-checking bench for uart_mmio (CLK_PER_BIT=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_mmio;

   localparam int          CPB  = 8;
   localparam logic [31:0] BASE = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rxd = 1'b1;
   logic txd;

   int n_vec = 0;
   int n_err = 0;

   logic [8:0] tx_q [$];

   uart_mmio_if bus ();

   uart_mmio #(
      .CLK_PER_BIT (CPB),
      .FIFO_DEPTH  (16),
      .BASE        (BASE)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .txd (txd),
      .rxd (rxd)
   );

   always #5 clk = ~clk;

   // Single comparison point for the whole bench.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      bus.adr       = a;
      bus.writedata = d;
      bus.memwrite  = 1'b1;
      step();
      bus.memwrite  = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
      bus.adr     = a;
      bus.memread = 1'b1;
      step();
      bus.memread = 1'b0;
      d = bus.readdata;
      h = bus.hit;
   endtask

   task automatic read_status(input string tag, input logic [31:0] exp);
      logic [31:0] d;
      logic        h;
      bus_read(BASE + 32'h8, d, h);
      check(tag, d, exp);
   endtask

   task automatic rx_send(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rxd = f[i];
         repeat (CPB) step();
      end
   endtask

   // Expected txd level k cycles after a TXDATA write (write cycle is k=0).
   function automatic logic exp_txd(input int k, input logic [7:0] b);
      int j;
      int p;
      j = k - 2;
      if (j < 0) return 1'b1;
      p = j / CPB;
      if (p == 0) return 1'b0;
      if (p <= 8) return b[p-1];
      return 1'b1;
   endfunction

   // Independent line decoder on txd: collects {stop_bit, byte}.
   initial begin : tx_monitor
      logic [7:0] b;
      logic       sb;
      forever begin
         step();
         if (txd === 1'b0) begin
            repeat (CPB / 2) step();
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) step();
               b[i] = txd;
            end
            repeat (CPB) step();
            sb = txd;
            tx_q.push_back({sb, b});
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      logic [31:0] d;
      logic        h;
      int          lowcnt;
      logic [8:0]  exp9;

      bus.adr       = 32'b0;
      bus.writedata = 32'b0;
      bus.memwrite  = 1'b0;
      bus.memread   = 1'b0;

      // Reset values
      repeat (3) step();
      check("rst_readdata", bus.readdata, 32'h0);
      check("rst_hit", {31'b0, bus.hit}, 32'h0);
      check("rst_txd", {31'b0, txd}, 32'h1);
      rst = 1'b0;
      step();
      read_status("rst_status", 32'h0);

      // Address decode
      bus_read(BASE + 32'hC, d, h);
      check("reg_c_data", d, 32'h0);
      check("reg_c_hit", {31'b0, h}, 32'h1);
      bus_read(BASE + 32'h10, d, h);
      check("miss_hit", {31'b0, h}, 32'h0);
      check("miss_data", d, 32'h0);
      bus_read(BASE + 32'h0, d, h);
      check("rx_empty_data", d, 32'h0);
      check("rx_empty_hit", {31'b0, h}, 32'h1);
      bus_read(BASE + 32'hB, d, h);
      check("status_lowbits_ignored", d, 32'h0);
      bus.adr       = BASE + 32'h8;
      bus.writedata = 32'h0;
      bus.memwrite  = 1'b1;
      bus.memread   = 1'b1;
      step();
      bus.memwrite  = 1'b0;
      bus.memread   = 1'b0;
      check("conflict_hit", {31'b0, bus.hit}, 32'h0);

      // Single TX frame, cycle-exact waveform
      tx_q.delete();
      bus_write(BASE + 32'h4, 32'h0A5);
      for (int k = 1; k <= 82; k++) begin
         check($sformatf("txd_k%0d", k), {31'b0, txd}, {31'b0, exp_txd(k, 8'hA5)});
         if (k == 1 || k == 40) begin
            bus_read(BASE + 32'h8, d, h);
            check("tx_busy_mid", {31'b0, d[2]}, 32'h1);
         end else begin
            step();
         end
      end
      read_status("tx_done_status", 32'h0);
      check("tx_single_count", tx_q.size(), 32'd1);
      if (tx_q.size() > 0) check("tx_single_byte", {23'b0, tx_q[0]}, 32'h1A5);
      tx_q.delete();

      // TX overflow: serializer busy with 0x11 while 17 bytes are pushed
      bus_write(BASE + 32'h4, 32'h11);
      step();
      step();
      for (int i = 0; i < 16; i++) bus_write(BASE + 32'h4, 32'h20 + i);
      read_status("tx_full_16", 32'h06);
      bus_write(BASE + 32'h4, 32'h5A);
      read_status("tx_ovf_17", 32'h16);
      bus_write(BASE + 32'h8, 32'h10);
      read_status("tx_ovf_clr", 32'h06);
      for (int t = 0; t < 20 * 10 * CPB && tx_q.size() < 17; t++) step();
      check("tx_frames", tx_q.size(), 32'd17);
      for (int i = 0; i < 17 && i < tx_q.size(); i++) begin
         exp9 = (i == 0) ? 9'h111 : {1'b1, 8'(32'h20 + i - 1)};
         check($sformatf("tx_frame%0d", i), {23'b0, tx_q[i]}, {23'b0, exp9});
      end
      repeat (10) step();
      read_status("tx_drained", 32'h0);

      // RX loopback
      rx_send(8'h3C, 1'b1);
      step();
      read_status("rx_valid", 32'h01);
      bus_read(BASE + 32'h0, d, h);
      check("rx_data", d, 32'h3C);
      check("rx_hit", {31'b0, h}, 32'h1);
      bus_read(BASE + 32'h0, d, h);
      check("rx_data_empty", d, 32'h0);
      read_status("rx_empty", 32'h0);

      // Start-bit glitch
      rxd = 1'b0;
      step();
      step();
      rxd = 1'b1;
      repeat (20) step();
      read_status("glitch", 32'h0);

      // Framing error
      rx_send(8'h55, 1'b0);
      rxd = 1'b1;
      repeat (4) step();
      read_status("frm_err", 32'h20);
      bus_write(BASE + 32'h8, 32'h20);
      read_status("frm_clr", 32'h0);

      // RX overrun: 17 frames, no reads
      for (int i = 0; i < 17; i++) rx_send(8'(8'h40 + i), 1'b1);
      step();
      read_status("rx_ovr", 32'h09);
      bus_write(BASE + 32'h8, 32'h08);
      read_status("rx_ovr_clr", 32'h01);

      // Full RX FIFO: read in the exact cycle of the stop-bit push
      fork
         rx_send(8'h77, 1'b1);
         begin
            repeat (3 + CPB / 2 + 9 * CPB) @(posedge clk);
            #1;
            bus.adr     = BASE;
            bus.memread = 1'b1;
            step();
            bus.memread = 1'b0;
            d = bus.readdata;
         end
      join
      check("pushpop_data", d, 32'h40);
      step();
      read_status("pushpop_status", 32'h01);
      for (int i = 0; i < 16; i++) begin
         bus_read(BASE + 32'h0, d, h);
         check($sformatf("rx_drain%0d", i), d, (i < 15) ? 32'h41 + i : 32'h77);
      end
      read_status("rx_drained", 32'h0);

      // Reset during TX data bit 3
      bus_write(BASE + 32'h4, 32'hC3);
      bus_write(BASE + 32'h4, 32'h3C);
      repeat (34) step();
      check("txd_bit3", {31'b0, txd}, 32'h0);
      rst         = 1'b1;
      bus.adr     = BASE + 32'h8;
      bus.memread = 1'b1;
      step();
      rst         = 1'b0;
      bus.memread = 1'b0;
      check("rst_mid_txd", {31'b0, txd}, 32'h1);
      check("rst_mid_readdata", bus.readdata, 32'h0);
      check("rst_mid_hit", {31'b0, bus.hit}, 32'h0);
      read_status("rst_mid_status", 32'h0);
      lowcnt = 0;
      for (int t = 0; t < 200; t++) begin
         step();
         if (txd !== 1'b1) lowcnt++;
      end
      check("no_frame_after_rst", lowcnt, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
